// File: rtl/jpeg_channel_scheduler.sv
// jpeg_channel_scheduler
//
// Shares one 8x8 DCT engine between the Y, Cb and Cr planes of a colour
// converted block. A block is latched on acceptance, then its three planes
// are issued to the engine in the fixed order Y, Cb, Cr. The channel of each
// issued beat is kept in an in-order tag FIFO. Each returning engine result
// is paired with the oldest tag, so downstream stages know which channel it
// belongs to.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   blk_valid/ready      block offer handshake (y_in, cb_in, cr_in)
//   eng_in_*             issue stream to the DCT engine
//   eng_out_*            result stream from the DCT engine
//   res_*                tagged result stream (registered)
//                        res_chan: 0=Y 1=Cb 2=Cr
//                        res_use_luma: result is luma
//                        res_last: result is Cr, the last beat of a block
//   busy                 block in issue, tags outstanding or result held
//   err_orphan           sticky: a result arrived with no tag outstanding
//   blk_done_count       blocks fully delivered downstream (wraps)
module jpeg_channel_scheduler #(
  parameter int DATA_WIDTH  = 15,
  parameter int PIXEL_COUNT = 64,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              blk_valid,
  output logic                              blk_ready,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] y_in,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cb_in,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] cr_in,
  output logic                              eng_in_valid,
  input  logic                              eng_in_ready,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0] eng_in_data,
  input  logic                              eng_out_valid,
  output logic                              eng_out_ready,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] eng_out_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [DATA_WIDTH*PIXEL_COUNT-1:0] res_data,
  output logic [1:0]                        res_chan,
  output logic                              res_use_luma,
  output logic                              res_last,
  output logic                              busy,
  output logic                              err_orphan,
  output logic [15:0]                       blk_done_count
);

  localparam int BW = DATA_WIDTH * PIXEL_COUNT;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISS_Y, ISS_CB, ISS_CR} state_t;

  state_t         state;
  state_t         state_nxt;

  logic [BW-1:0]  y_buf;
  logic [BW-1:0]  cb_buf;
  logic [BW-1:0]  cr_buf;

  logic [1:0]     tag_mem [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  tag_count;
  logic [1:0]     cur_tag;

  logic           accept;
  logic           push;
  logic           ret_fire;
  logic           pop;
  logic           orphan;
  logic           res_fire;

  // Handshake decode. eng_in_valid looks only at the registered tag count,
  // so a pop in this cycle frees a slot for issue in the next cycle.
  assign blk_ready     = (state == IDLE);
  assign accept        = blk_valid && blk_ready;
  assign eng_in_valid  = (state != IDLE) && (tag_count < CW'(TAG_DEPTH));
  assign push          = eng_in_valid && eng_in_ready;
  assign eng_out_ready = !res_valid || res_ready;
  assign ret_fire      = eng_out_valid && eng_out_ready;
  assign pop           = ret_fire && (tag_count != '0);
  assign orphan        = ret_fire && (tag_count == '0);
  assign res_fire      = res_valid && res_ready;

  assign res_use_luma  = (res_chan == 2'd0);
  assign res_last      = (res_chan == 2'd2);
  assign busy          = (state != IDLE) || (tag_count != '0) || res_valid;

  // Issue FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Issue FSM: next state and issued plane. The engine sees zero while idle.
  always_comb begin
    state_nxt   = state;
    eng_in_data = '0;
    cur_tag     = 2'd0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISS_Y;
      end
      ISS_Y: begin
        eng_in_data = y_buf;
        cur_tag     = 2'd0;
        if (push) state_nxt = ISS_CB;
      end
      ISS_CB: begin
        eng_in_data = cb_buf;
        cur_tag     = 2'd1;
        if (push) state_nxt = ISS_CR;
      end
      ISS_CR: begin
        eng_in_data = cr_buf;
        cur_tag     = 2'd2;
        if (push) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Block buffer: only read while the FSM is issuing, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      y_buf  <= y_in;
      cb_buf <= cb_in;
      cr_buf <= cr_in;
    end
  end

  // Tag FIFO storage; pointers wrap naturally since TAG_DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= cur_tag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   tag_count <= tag_count + CW'(1);
        2'b01:   tag_count <= tag_count - CW'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Result register: loaded from the engine with the oldest tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_chan       <= 2'd0;
      err_orphan     <= 1'b0;
      blk_done_count <= 16'd0;
    end else begin
      if (pop) begin
        res_valid <= 1'b1;
        res_data  <= eng_out_data;
        res_chan  <= tag_mem[rd_ptr];
      end else if (res_fire) begin
        res_valid <= 1'b0;
      end
      if (orphan) err_orphan <= 1'b1;
      if (res_fire && res_last) blk_done_count <= blk_done_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_jpeg_channel_scheduler.sv
module tb_jpeg_channel_scheduler;

  localparam int DW = 15;
  localparam int PC = 64;
  localparam int TD = 4;
  localparam int BW = DW * PC;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          blk_valid;
  logic          blk_ready;
  logic [BW-1:0] y_in, cb_in, cr_in;
  logic          eng_in_valid;
  logic          eng_in_ready;
  logic [BW-1:0] eng_in_data;
  logic          eng_out_valid;
  logic          eng_out_ready;
  logic [BW-1:0] eng_out_data;
  logic          res_valid;
  logic          res_ready;
  logic [BW-1:0] res_data;
  logic [1:0]    res_chan;
  logic          res_use_luma;
  logic          res_last;
  logic          busy;
  logic          err_orphan;
  logic [15:0]   blk_done_count;

  always #5 clk = ~clk;

  jpeg_channel_scheduler #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset_n(reset_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .y_in(y_in), .cb_in(cb_in), .cr_in(cr_in),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_chan(res_chan), .res_use_luma(res_use_luma), .res_last(res_last),
    .busy(busy), .err_orphan(err_orphan), .blk_done_count(blk_done_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: blocks are expanded into the beats they must produce,
  // in Y, Cb, Cr order; the engine is an in-order identity with a delay.
  int cyc = 0;
  int eq_d[$];
  int eq_t[$];
  int lat_min = 3;
  int lat_max = 3;
  bit eng_rnd = 1'b0;
  bit eng_en = 1'b1;
  int eng_allow = -1;
  bit rnd_ready = 1'b0;
  int exp_iss[$];
  int exp_rd[$];
  int exp_rc[$];
  int done_cnt = 0;
  int n_iss = 0;
  int n_out = 0;
  int last_blk_edge = 0;
  int last_out_edge = 0;
  int iss_edges[$];
  int got_d[$];
  int got_c[$];

  typedef struct {
    int y; int cb; int cr;
    int e0; int e1; int e2;
    int cnt;
  } vec_t;
  vec_t vt[4];

  function automatic logic [BW-1:0] rep(input int v);
    logic [BW-1:0] r;
    for (int i = 0; i < PC; i++) r[i*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  // Sample value of a uniformly filled block, or -1 if samples differ.
  function automatic int comp(input logic [BW-1:0] d);
    logic [DW-1:0] s0;
    s0 = d[DW-1:0];
    for (int i = 1; i < PC; i++) if (d[i*DW +: DW] != s0) return -1;
    return int'({17'b0, s0});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic offer(input int y, input int cb, input int cr);
    y_in = rep(y); cb_in = rep(cb); cr_in = rep(cr);
    blk_valid = 1'b1;
  endtask

  task automatic clear_model();
    eq_d.delete(); eq_t.delete();
    exp_iss.delete(); exp_rd.delete(); exp_rc.delete();
    done_cnt = 0;
    blk_valid = 1'b0;
    eng_out_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string p);
    chk({p, "_blk_ready"}, blk_ready, 1);
    chk({p, "_eng_in_valid"}, eng_in_valid, 0);
    chk({p, "_eng_in_data"}, comp(eng_in_data), 0);
    chk({p, "_eng_out_ready"}, eng_out_ready, 1);
    chk({p, "_res_valid"}, res_valid, 0);
    chk({p, "_res_data"}, comp(res_data), 0);
    chk({p, "_res_chan"}, res_chan, 0);
    chk({p, "_res_use_luma"}, res_use_luma, 1);
    chk({p, "_res_last"}, res_last, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err_orphan"}, err_orphan, 0);
    chk({p, "_blk_done_count"}, blk_done_count, 0);
  endtask

  // One clock: sample handshakes before the edge, update model after it.
  task automatic tick();
    bit in_hs, out_hs, res_hs, blk_hs;
    int in_d, res_d, res_c, res_l, res_u, by, bc, br, t, ed, ec;
    @(negedge clk);
    in_hs  = eng_in_valid && eng_in_ready;
    in_d   = comp(eng_in_data);
    out_hs = eng_out_valid && eng_out_ready;
    res_hs = res_valid && res_ready;
    res_d  = comp(res_data);
    res_c  = int'(res_chan);
    res_l  = int'(res_last);
    res_u  = int'(res_use_luma);
    blk_hs = blk_valid && blk_ready;
    by = comp(y_in); bc = comp(cb_in); br = comp(cr_in);
    @(posedge clk);
    #1;
    cyc++;
    if (blk_hs) begin
      exp_iss.push_back(by); exp_iss.push_back(bc); exp_iss.push_back(br);
      exp_rd.push_back(by);  exp_rd.push_back(bc);  exp_rd.push_back(br);
      exp_rc.push_back(0);   exp_rc.push_back(1);   exp_rc.push_back(2);
      blk_valid = 1'b0;
      last_blk_edge = cyc;
    end
    if (in_hs) begin
      n_iss++;
      iss_edges.push_back(cyc);
      if (exp_iss.size() == 0) chk("issue_unexpected", in_d, -2);
      else chk("issue_data", in_d, exp_iss.pop_front());
      if (eng_en) begin
        t = cyc + lat_min + int'($urandom_range(lat_max - lat_min));
        if (eq_t.size() > 0 && t < eq_t[$]) t = eq_t[$];
        eq_d.push_back(in_d);
        eq_t.push_back(t);
      end
    end
    if (out_hs && eng_en && eq_d.size() > 0) begin
      void'(eq_d.pop_front());
      void'(eq_t.pop_front());
      n_out++;
      last_out_edge = cyc;
      if (eng_allow > 0) eng_allow--;
    end
    if (res_hs) begin
      got_d.push_back(res_d);
      got_c.push_back(res_c);
      if (exp_rd.size() == 0) chk("res_unexpected", res_d, -2);
      else begin
        ed = exp_rd.pop_front();
        ec = exp_rc.pop_front();
        chk("res_data", res_d, ed);
        chk("res_chan", res_c, ec);
        chk("res_last", res_l, (ec == 2) ? 1 : 0);
        chk("res_use_luma", res_u, (ec == 0) ? 1 : 0);
        if (ec == 2) done_cnt++;
        chk("blk_done_count", int'(blk_done_count), done_cnt);
      end
    end
    if (eng_en) begin
      if (eq_d.size() > 0 && eq_t[0] <= cyc && eng_allow != 0 &&
          (!eng_rnd || $urandom_range(3) != 0)) begin
        eng_out_valid = 1'b1;
        eng_out_data  = rep(eq_d[0]);
      end else begin
        eng_out_valid = 1'b0;
      end
    end
    if (rnd_ready) begin
      eng_in_ready = ($urandom_range(3) != 0);
      res_ready    = ($urandom_range(2) != 0);
    end
  endtask

  task automatic drain(input string p);
    int n;
    rnd_ready = 1'b0; eng_rnd = 1'b0; eng_allow = -1;
    eng_in_ready = 1'b1; res_ready = 1'b1;
    n = 0;
    while ((blk_valid || exp_rd.size() > 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    chk({p, "_drain_pending"}, exp_rd.size(), 0);
    chk({p, "_drain_busy"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n, k;
    bit sent_b;
    int hold_d, hold_c;

    reset_n = 1'b1; blk_valid = 1'b0;
    y_in = '0; cb_in = '0; cr_in = '0;
    eng_in_ready = 1'b1; eng_out_valid = 1'b0; eng_out_data = '0; res_ready = 1'b1;
    #1 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_values("reset");
    reset_n = 1'b1;

    // Table-driven single blocks with identity engine, latency 3.
    vt[0] = '{32'h0010, 32'h0020, 32'h0030, 32'h0010, 32'h0020, 32'h0030, 1};
    vt[1] = '{32'h0000, 32'h7fff, 32'h1234, 32'h0000, 32'h7fff, 32'h1234, 2};
    vt[2] = '{32'h7fff, 32'h0001, 32'h4000, 32'h7fff, 32'h0001, 32'h4000, 3};
    vt[3] = '{32'h0005, 32'h0006, 32'h0007, 32'h0005, 32'h0006, 32'h0007, 4};
    for (int v = 0; v < 4; v++) begin
      got_d.delete(); got_c.delete(); iss_edges.delete();
      offer(vt[v].y, vt[v].cb, vt[v].cr);
      n = 0;
      while (got_d.size() < 3 && n < 40) begin tick(); n++; end
      chk("tbl_beats", got_d.size(), 3);
      if (got_d.size() == 3 && iss_edges.size() == 3) begin
        chk("tbl_d0", got_d[0], vt[v].e0);
        chk("tbl_d1", got_d[1], vt[v].e1);
        chk("tbl_d2", got_d[2], vt[v].e2);
        chk("tbl_c0", got_c[0], 0);
        chk("tbl_c1", got_c[1], 1);
        chk("tbl_c2", got_c[2], 2);
        for (int i = 0; i < 3; i++) chk("tbl_issue_edge", iss_edges[i] - last_blk_edge, i + 1);
      end
      chk("tbl_done_count", int'(blk_done_count), vt[v].cnt);
      tick(); tick();
      chk("tbl_busy_idle", busy, 0);
      chk("tbl_blk_ready", blk_ready, 1);
    end

    // Engine input stalled for 5 cycles while Cb is offered.
    n0 = n_iss;
    offer(32'h101, 32'h202, 32'h303);
    n = 0;
    while (n_iss == n0 && n < 20) begin tick(); n++; end
    chk("stall_y_issued", n_iss - n0, 1);
    eng_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", eng_in_valid, 1);
      chk("stall_data", comp(eng_in_data), 32'h202);
      tick();
    end
    chk("stall_no_issue", n_iss - n0, 1);
    eng_in_ready = 1'b1;
    tick();
    chk("stall_cb_issue", n_iss - n0, 2);
    tick();
    chk("stall_cr_issue", n_iss - n0, 3);
    drain("stall");

    // Tag FIFO fills when the engine never returns.
    eng_allow = 0;
    n0 = n_iss;
    sent_b = 1'b0;
    offer(32'h11, 32'h12, 32'h13);
    for (int i = 0; i < 15; i++) begin
      if (!blk_valid && !sent_b) begin
        offer(32'h21, 32'h22, 32'h23);
        sent_b = 1'b1;
      end
      tick();
    end
    chk("full_issue_count", n_iss - n0, 4);
    chk("full_in_valid", eng_in_valid, 0);
    chk("full_blk_ready", blk_ready, 0);
    chk("full_busy", busy, 1);
    eng_allow = 1;
    k = n_out;
    n = 0;
    while (n_out == k && n < 10) begin tick(); n++; end
    chk("full_one_return", n_out - k, 1);
    n = 0;
    while (n_iss - n0 < 5 && n < 10) begin tick(); n++; end
    chk("full_cb2_issue", n_iss - n0, 5);
    if (iss_edges.size() > 0) chk("full_cb2_edge", iss_edges[$] - last_out_edge, 1);
    drain("full");

    // Results held by downstream backpressure.
    res_ready = 1'b0;
    lat_min = 1; lat_max = 1;
    got_d.delete(); got_c.delete();
    offer(32'h31, 32'h32, 32'h33);
    for (int i = 0; i < 12; i++) tick();
    chk("hold_res_valid", res_valid, 1);
    chk("hold_eng_out_ready", eng_out_ready, 0);
    hold_d = comp(res_data);
    hold_c = int'(res_chan);
    chk("hold_data", hold_d, 32'h31);
    chk("hold_chan", hold_c, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("hold_data_stable", comp(res_data), 32'h31);
    chk("hold_chan_stable", res_chan, 0);
    drain("hold");
    if (got_c.size() >= 2) begin
      chk("hold_order0", got_c[0], 0);
      chk("hold_order1", got_c[1], 1);
    end else chk("hold_beats", got_c.size(), 3);

    // Randomized traffic against the model.
    rnd_ready = 1'b1; eng_rnd = 1'b1; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 1500; i++) begin
      if (!blk_valid && $urandom_range(2) == 0)
        offer(int'($urandom_range(32767)), int'($urandom_range(32767)), int'($urandom_range(32767)));
      tick();
    end
    drain("rand");
    chk("rand_iss_left", exp_iss.size(), 0);
    chk("rand_err_orphan", err_orphan, 0);
    chk("rand_done_count", int'(blk_done_count), done_cnt & 32'hffff);

    // Orphan result after reset.
    reset_n = 1'b0;
    clear_model();
    @(posedge clk); #1;
    reset_n = 1'b1;
    eng_en = 1'b0;
    eng_out_valid = 1'b1;
    eng_out_data = rep(32'h55);
    #1;
    chk("orphan_out_ready", eng_out_ready, 1);
    tick();
    eng_out_valid = 1'b0;
    chk("orphan_flag", err_orphan, 1);
    chk("orphan_res_valid", res_valid, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("orphan_sticky", err_orphan, 1);
    chk("orphan_busy", busy, 0);
    eng_en = 1'b1;

    // Reset arriving mid-block, just after the Cb issue.
    lat_min = 3; lat_max = 3;
    offer(32'h41, 32'h42, 32'h43);
    drain("pre_rst");
    chk("pre_rst_count", int'(blk_done_count), 1);
    n0 = n_iss;
    offer(32'h51, 32'h52, 32'h53);
    n = 0;
    while (n_iss - n0 < 2 && n < 20) begin tick(); n++; end
    chk("mid_cb_issued", n_iss - n0, 2);
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    clear_model();
    @(posedge clk); #1;
    reset_n = 1'b1;
    got_d.delete(); got_c.delete();
    offer(32'h61, 32'h62, 32'h63);
    drain("post_rst");
    if (got_d.size() > 0) begin
      chk("post_rst_first_data", got_d[0], 32'h61);
      chk("post_rst_first_chan", got_c[0], 0);
    end else chk("post_rst_beats", got_d.size(), 3);
    chk("post_rst_count", int'(blk_done_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
